usb_cmd_engine: RTL

- Parametrised successor of the serial command decoder; sits between the USB byte receiver and the register file.
- Parses a header byte, a little-endian length field of configurable size, then one of two payload phases:
  - write mode: payload bytes stream from the host into the registers;
  - read mode: register bytes stream out to the host through a valid/ready transmit handshake.
- Adds exact byte counting, reserved-mode rejection and an inter-byte timeout.

---
 rtl/usb_cmd_engine.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/usb_cmd_engine.sv
// USB command engine: parses header + little-endian length, then streams
// payload bytes into the register file (write) or out through tx (read).
module usb_cmd_engine #(
  parameter int unsigned LEN_BYTES      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk_usb,
  input  logic                   reset_n,
  input  logic                   byte_ready,
  input  logic [7:0]             reg_usb_data_in,
  output logic [5:0]             reg_cmd,
  output logic [8*LEN_BYTES-1:0] reg_bytecount,
  output logic [7:0]             reg_data_in,
  output logic                   reg_write,
  output logic                   reg_read,
  input  logic [7:0]             reg_data_out,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   cmd_error
);

  localparam int unsigned LEN_W = 8 * LEN_BYTES;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]       LEN_LAST = 2'(LEN_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(TIMEOUT_CYCLES);
  localparam bit               TMR_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    HDR     = 3'd0,
    LEN     = 3'd1,
    WR_DATA = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    RD_SEND = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0] len, len_nxt, len_acc;
  logic [LEN_W-1:0] k, k_nxt;
  logic [1:0]       lcnt, lcnt_nxt;
  logic             mode_wr, mode_wr_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             tmo;
  logic             k_last;

  logic [5:0]       cmd_nxt;
  logic [LEN_W-1:0] bc_nxt;
  logic [7:0]       din_nxt;
  logic             write_nxt, read_nxt, txv_nxt, err_nxt;
  logic [7:0]       txd_nxt;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HDR;
      len           <= '0;
      k             <= '0;
      lcnt          <= '0;
      mode_wr       <= 1'b0;
      tmr           <= '0;
      reg_cmd       <= '0;
      reg_bytecount <= '0;
      reg_data_in   <= '0;
      reg_write     <= 1'b0;
      reg_read      <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      cmd_error     <= 1'b0;
    end else begin
      state         <= state_nxt;
      len           <= len_nxt;
      k             <= k_nxt;
      lcnt          <= lcnt_nxt;
      mode_wr       <= mode_wr_nxt;
      tmr           <= tmr_nxt;
      reg_cmd       <= cmd_nxt;
      reg_bytecount <= bc_nxt;
      reg_data_in   <= din_nxt;
      reg_write     <= write_nxt;
      reg_read      <= read_nxt;
      tx_valid      <= txv_nxt;
      tx_data       <= txd_nxt;
      cmd_error     <= err_nxt;
    end
  end

  assign busy    = (state != HDR);
  assign len_acc = len | (LEN_W'(reg_usb_data_in) << {lcnt, 3'b000});
  assign k_last  = (k == len - LEN_W'(1));
  assign tmo     = TMR_EN && (tmr == TMR_END);

  always_comb begin
    state_nxt   = state;
    len_nxt     = len;
    k_nxt       = k;
    lcnt_nxt    = lcnt;
    mode_wr_nxt = mode_wr;
    cmd_nxt     = reg_cmd;
    bc_nxt      = reg_bytecount;
    din_nxt     = reg_data_in;
    write_nxt   = 1'b0;
    read_nxt    = 1'b0;
    txv_nxt     = tx_valid;
    txd_nxt     = tx_data;
    err_nxt     = 1'b0;

    case (state)
      HDR: begin
        if (byte_ready) begin
          cmd_nxt     = reg_usb_data_in[5:0];
          mode_wr_nxt = reg_usb_data_in[6];
          len_nxt     = '0;
          k_nxt       = '0;
          lcnt_nxt    = '0;
          bc_nxt      = '0;
          // modes 00/01 are reserved; only 10 (read) and 11 (write) start a frame
          if (!reg_usb_data_in[7]) err_nxt = 1'b1;
          else                     state_nxt = LEN;
        end
      end
      LEN: begin
        if (byte_ready) begin
          len_nxt  = len_acc;
          lcnt_nxt = lcnt + 2'd1;
          if (lcnt == LEN_LAST) begin
            if (len_acc == '0) begin
              state_nxt = HDR;
            end else if (mode_wr) begin
              state_nxt = WR_DATA;
            end else begin
              state_nxt = RD_REQ;
              read_nxt  = 1'b1;
              bc_nxt    = k;
            end
          end
        end else if (tmo) begin
          err_nxt   = 1'b1;
          state_nxt = HDR;
        end
      end
      WR_DATA: begin
        if (byte_ready) begin
          din_nxt   = reg_usb_data_in;
          bc_nxt    = k;
          write_nxt = 1'b1;
          k_nxt     = k + LEN_W'(1);
          if (k_last) state_nxt = HDR;
        end else if (tmo) begin
          err_nxt   = 1'b1;
          state_nxt = HDR;
        end
      end
      RD_REQ: begin
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        txd_nxt   = reg_data_out;
        txv_nxt   = 1'b1;
        state_nxt = RD_SEND;
      end
      RD_SEND: begin
        if (tx_ready) begin
          txv_nxt = 1'b0;
          k_nxt   = k + LEN_W'(1);
          if (k_last) begin
            state_nxt = HDR;
          end else begin
            state_nxt = RD_REQ;
            read_nxt  = 1'b1;
            bc_nxt    = k + LEN_W'(1);
          end
        end
      end
      default: state_nxt = HDR;
    endcase

    // idle counter restarts on any byte and on every state change; saturates at the limit
    if (state_nxt != state || byte_ready)
      tmr_nxt = '0;
    else if (TMR_EN && (state == LEN || state == WR_DATA) && !tmo)
      tmr_nxt = tmr + TMR_W'(1);
    else
      tmr_nxt = tmr;
  end

endmodule
